// File: rtl/memory_queue.sv
// Single-clock FIFO with registered read port, occupancy reporting and
// sticky overflow/underflow flags.
module memory_queue #(
    parameter int unsigned WIDTH     = 35,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_LVL = 6
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       wren,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rden,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       ovf,
    output logic                       udf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wptr_q,  wptr_d;
    logic [AW-1:0]    rptr_q,  rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q,   ovf_d;
    logic             udf_q,   udf_d;

    logic             wa;
    logic             ra;

    // Status decoded from the count register only, so it never glitches.
    assign empty       = (count_q == CW'(0));
    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AFULL_LVL));

    // A full queue still accepts a write when a read frees a slot this edge;
    // an empty queue never forwards din to the read port.
    assign wa = wren & (~full | rden);
    assign ra = rden & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (wa) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (ra) begin
            rptr_d  = rptr_q + AW'(1);
            dout_d  = mem_q[rptr_q];
            valid_d = 1'b1;
        end

        case ({wa, ra})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wren & ~wa) begin
            ovf_d = 1'b1;
        end
        if (rden & ~ra) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array is deliberately not reset; stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem_q[wptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_memory_queue.sv
// Self-checking bench for memory_queue: directed scenarios followed by random
// strobes, all compared against a queue-based reference model.
module tb_memory_queue;

    localparam int unsigned WIDTH     = 35;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned AFULL_LVL = 6;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic             clk;
    logic             arst;
    logic             wren;
    logic [WIDTH-1:0] din;
    logic             rden;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             ovf;
    logic             udf;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    logic             m_ovf;
    logic             m_udf;

    memory_queue #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .wren        (wren),
        .din         (din),
        .rden        (rden),
        .dout        (dout),
        .valid       (valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .ovf         (ovf),
        .udf         (udf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        check({tag, ".dout"},  64'(dout),        64'(m_dout));
        check({tag, ".valid"}, 64'(valid),       64'(m_valid));
        check({tag, ".count"}, 64'(count),       64'(n));
        check({tag, ".empty"}, 64'(empty),       64'(n == 0));
        check({tag, ".full"},  64'(full),        64'(n == DEPTH));
        check({tag, ".afull"}, 64'(almost_full), 64'(n >= AFULL_LVL));
        check({tag, ".ovf"},   64'(ovf),         64'(m_ovf));
        check({tag, ".udf"},   64'(udf),         64'(m_udf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Reference behaviour: pop first, then push if there was room before the
    // edge or the same-cycle pop made room.
    task automatic model_edge(input logic w, input logic [WIDTH-1:0] d, input logic r);
        int pre;
        pre     = mq.size();
        m_valid = 1'b0;
        if (r) begin
            if (pre > 0) begin
                m_dout  = mq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_udf = 1'b1;
            end
        end
        if (w) begin
            if (pre < DEPTH || r) mq.push_back(d);
            else                  m_ovf = 1'b1;
        end
    endtask

    task automatic step(input string tag, input logic w, input logic [WIDTH-1:0] d, input logic r);
        wren = w;
        din  = d;
        rden = r;
        @(posedge clk);
        model_edge(w, d, r);
        #1;
        check_all(tag);
        wren = 1'b0;
        rden = 1'b0;
    endtask

    // Pulse reset between rising edges; outputs must react without a clock.
    task automatic mid_reset(input string tag);
        #1;
        arst = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".during"});
        #9;
        arst = 1'b0;
        #1;
        check_all({tag, ".after"});
    endtask

    initial begin
        wren = 1'b0;
        rden = 1'b0;
        din  = '0;
        arst = 1'b0;
        model_reset();

        // Reset asserted before any clock edge.
        #5;
        arst = 1'b1;
        #1;
        check_all("rst0");
        #6;
        arst = 1'b0;
        #1;
        check_all("rst0_rel");

        // Fill with 1..8.
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1'b1, WIDTH'(i), 1'b0);
            if (i == AFULL_LVL - 1) check("afull_before", 64'(almost_full), 64'(0));
            if (i == AFULL_LVL)     check("afull_at",     64'(almost_full), 64'(1));
        end
        check("full_after_fill", 64'(full), 64'(1));

        // Rejected write while full.
        step("ovf", 1'b1, 35'h3F0000002, 1'b0);
        check("ovf_set", 64'(ovf), 64'(1));
        check("ovf_count", 64'(count), 64'(DEPTH));

        // Simultaneous read+write while full.
        for (int i = 0; i < 4; i++) begin
            step("fullrw", 1'b1, WIDTH'(9 + i), 1'b1);
            check("fullrw_dout", 64'(dout), 64'(1 + i));
        end

        // Drain across the pointer wrap: 5..12.
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1);
            check("drain_dout", 64'(dout), 64'(5 + i));
            check("drain_valid", 64'(valid), 64'(1));
        end
        check("empty_after_drain", 64'(empty), 64'(1));

        // Rejected read while empty: dout holds.
        step("udf", 1'b0, '0, 1'b1);
        check("udf_set", 64'(udf), 64'(1));
        check("udf_hold", 64'(dout), 64'(12));

        // Read+write while empty: no fall-through.
        step("emptyrw", 1'b1, WIDTH'(2), 1'b1);
        check("emptyrw_count", 64'(count), 64'(1));
        check("emptyrw_valid", 64'(valid), 64'(0));
        step("emptyrw_rd", 1'b0, '0, 1'b1);
        check("emptyrw_dout", 64'(dout), 64'(2));

        // Reset with five entries queued.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, WIDTH'(20 + i), 1'b0);
        check("pre_rst_count", 64'(count), 64'(5));
        mid_reset("rst_mid");
        step("post_rst_wr", 1'b1, WIDTH'(2), 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1);
        check("post_rst_dout", 64'(dout), 64'(2));

        // Random traffic: write-biased, then read-biased, then balanced.
        for (int i = 0; i < 600; i++) begin
            logic w;
            logic r;
            int   wp;
            int   rp;
            wp = (i < 200) ? 75 : (i < 400) ? 30 : 55;
            rp = (i < 200) ? 35 : (i < 400) ? 75 : 55;
            w  = ($urandom_range(0, 99) < wp);
            r  = ($urandom_range(0, 99) < rp);
            step("rand", w, WIDTH'({$urandom(), $urandom()}), r);
            if (i == 300) mid_reset("rst_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
